dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arb_picker.sv | 29 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_CPU   = 0;
    localparam int PORT_DBG   = 1;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports sharing
// one response channel. master = requesters, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic              req_we0;
    logic              req_we1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr0, req_addr1, req_we0, req_we1,
               req_wdata0, req_wdata1, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_we0, req_we1,
               req_wdata0, req_wdata1, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arb_picker.sv
// Combinational grant for the two requesters.
// DMEM_ARB_RR_EN defined : round-robin on a tie (rr_last = id of last winner).
// DMEM_ARB_RR_EN undefined: fixed priority, port 0 wins a tie.
module dmem_arb_picker
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_valid,
`ifdef DMEM_ARB_RR_EN
    input  logic                 rr_last,
`endif
    output logic [NUM_PORTS-1:0] grant
);

    // one-hot grant; only a tie needs a decision
    always_comb begin
        grant = '0;
        if (req_valid[PORT_CPU] && req_valid[PORT_DBG]) begin
`ifdef DMEM_ARB_RR_EN
            if (rr_last) grant[PORT_CPU] = 1'b1;
            else         grant[PORT_DBG] = 1'b1;
`else
            grant[PORT_CPU] = 1'b1;
`endif
        end else begin
            grant = req_valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port byte memory between the CPU (port 0) and
// the loader/debug master (port 1). One request is latched, one memory cycle
// runs, then the response is held until the owner takes it.
// Optional macro: DMEM_ARB_RR_EN selects round-robin tie-breaking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Highest legal word base. Addresses whose +3 wraps are far above this,
    // so a single compare also rejects wrapped accesses.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - WORD_BYTES);

    state_e              state_q, state_d;
    logic [NUM_PORTS-1:0] grant;
    logic                accept;

    logic                sel_id;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wdata;

    logic                id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

`ifdef DMEM_ARB_RR_EN
    logic                rr_last;

    dmem_arb_picker u_picker (
        .req_valid (bus.req_valid),
        .rr_last   (rr_last),
        .grant     (grant)
    );
`else
    dmem_arb_picker u_picker (
        .req_valid (bus.req_valid),
        .grant     (grant)
    );
`endif

    assign sel_id    = grant[PORT_DBG];
    assign sel_addr  = sel_id ? bus.req_addr1  : bus.req_addr0;
    assign sel_we    = sel_id ? bus.req_we1    : bus.req_we0;
    assign sel_wdata = sel_id ? bus.req_wdata1 : bus.req_wdata0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state and all handshake/memory outputs
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        mem_address    = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        unique case (state_q)
            IDLE: begin
                // no grant while reset is held: nothing would be latched
                if (|grant && rst_n) begin
                    bus.req_ready = grant;
                    accept        = 1'b1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                mem_address    = addr_q;
                mem_write_en   = we_q & ~err_q;
                mem_write_data = wdata_q;
                state_d        = RESP;
            end
            RESP: begin
                bus.resp_valid[id_q] = 1'b1;
                if (bus.resp_ready[id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign bus.resp_err   = (state_q == RESP) & err_q;

    // latch the accepted request and capture read data in the memory cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                id_q    <= sel_id;
                addr_q  <= sel_addr;
                we_q    <= sel_we;
                err_q   <= (sel_addr > LAST_BASE);
                wdata_q <= sel_wdata;
            end
            if (state_q == ACCESS)
                rdata_q <= (we_q || err_q) ? '0 : mem_read_data;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // remember the last winner; reset value lets port 0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_last <= 1'b1;
        else if (accept) rr_last <= sel_id;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a 12-byte memory model and a
// response scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // memory device and the bench's expected image of it
    logic [7:0] mem    [MEM_BYTES] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                                       8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    logic [7:0] shadow [MEM_BYTES] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                                       8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    int we_count = 0;

    always_comb begin
        mem_read_data = '0;
        if (mem_address <= 32'(MEM_BYTES - 4))
            for (int b = 0; b < 4; b++)
                mem_read_data[8*b +: 8] = mem[int'(mem_address) + b];
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            we_count <= we_count + 1;
            if (mem_address <= 32'(MEM_BYTES - 4))
                for (int b = 0; b < 4; b++)
                    mem[int'(mem_address) + b] <= mem_write_data[8*b +: 8];
        end
    end

    function automatic logic [31:0] shadow_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = shadow[a + b];
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[a + b];
        return w;
    endfunction

    function automatic void shadow_write(input int a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) shadow[a + b] = w[8*b +: 8];
    endfunction

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // drive one request and wait (bounded) for its acceptance; returns in ACCESS
    task automatic accept_req(input int port, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata);
        bit ok = 0;
        if (port == 0) begin
            bus.req_addr0 = addr; bus.req_we0 = we; bus.req_wdata0 = wdata;
        end else begin
            bus.req_addr1 = addr; bus.req_we1 = we; bus.req_wdata1 = wdata;
        end
        bus.req_valid[port] = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (bus.req_ready[port]) ok = 1;
            @(posedge clk); #1;
        end
        bus.req_valid[port] = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout port=%0d", port);
        end
    endtask

    // wait (bounded) for a response; cycles = edges waited
    task automatic wait_resp(output logic [1:0] v, output logic [31:0] d,
                             output logic e, output int cycles);
        cycles = 0;
        while (bus.resp_valid == 2'b00 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        v = bus.resp_valid; d = bus.resp_rdata; e = bus.resp_err;
        if (cycles >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout");
        end
    endtask

    task automatic ack();
        bus.resp_ready = bus.resp_valid;
        @(posedge clk); #1;
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=00", bus.resp_valid); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata got=%h exp=0", bus.resp_rdata); end
        n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL rst_mem_address got=%h exp=0", mem_address); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write_en got=%b exp=0", mem_write_en); end
        n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_mem_write_data got=%h exp=0", mem_write_data); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_req_ready got=%b exp=00", bus.req_ready); end
    endtask

    task automatic test_write();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        sb.push_back('{id: 2'b01, rdata: 32'h0, err: 1'b0});
        shadow_write(4, 32'hDEADBEEF);
        accept_req(0, 32'd4, 1'b1, 32'hDEADBEEF);
        n_checks++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL wr_access_we got=%b exp=1", mem_write_en); end
        n_checks++; if (mem_address !== 32'd4) begin n_fail++; $display("FAIL wr_access_addr got=%h exp=4", mem_address); end
        n_checks++; if (mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_access_data got=%h exp=deadbeef", mem_write_data); end
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL wr_latency extra_cycles=%0d exp=0", cyc); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL wr_we_one_cycle got=%b exp=0", mem_write_en); end
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL wr_resp_valid got=%b exp=%b", v, x.id); end
        n_checks++; if (e !== x.err) begin n_fail++; $display("FAIL wr_resp_err got=%b exp=%b", e, x.err); end
        n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL wr_resp_rdata got=%h exp=%h", d, x.rdata); end
        n_checks++; if (mem_word(4) !== shadow_word(4)) begin n_fail++; $display("FAIL wr_mem_word got=%h exp=%h", mem_word(4), shadow_word(4)); end
        ack();
    endtask

    task automatic test_readback();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        sb.push_back('{id: 2'b10, rdata: shadow_word(4), err: 1'b0});
        accept_req(1, 32'd4, 1'b0, 32'h0);
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rd_access_we got=%b exp=0", mem_write_en); end
        n_checks++; if (mem_address !== 32'd4) begin n_fail++; $display("FAIL rd_access_addr got=%h exp=4", mem_address); end
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL rd_latency extra_cycles=%0d exp=0", cyc); end
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL rd_resp_valid got=%b exp=%b", v, x.id); end
        n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL rd_resp_rdata got=%h exp=%h", d, x.rdata); end
        n_checks++; if (e !== x.err) begin n_fail++; $display("FAIL rd_resp_err got=%b exp=%b", e, x.err); end
        ack();
    endtask

    task automatic test_tie();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        logic [1:0] g1, g2;
        g1 = 2'b01;
`ifdef DMEM_ARB_RR_EN
        g2 = 2'b10;
`else
        g2 = 2'b01;
`endif
        bus.req_addr0 = 32'd0; bus.req_we0 = 1'b0; bus.req_wdata0 = 32'h0;
        bus.req_addr1 = 32'd8; bus.req_we1 = 1'b0; bus.req_wdata1 = 32'h0;
        bus.req_valid = 2'b11;
        #1;
        n_checks++; if (bus.req_ready !== g1) begin n_fail++; $display("FAIL tie_grant1 got=%b exp=%b", bus.req_ready, g1); end
        sb.push_back('{id: g1, rdata: shadow_word(g1[1] ? 8 : 0), err: 1'b0});
        @(posedge clk); #1;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL tie_access_ready got=%b exp=00", bus.req_ready); end
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL tie_resp1_valid got=%b exp=%b", v, x.id); end
        n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL tie_resp1_rdata got=%h exp=%h", d, x.rdata); end
        ack();
        n_checks++; if (bus.req_ready !== g2) begin n_fail++; $display("FAIL tie_grant2 got=%b exp=%b", bus.req_ready, g2); end
        sb.push_back('{id: g2, rdata: shadow_word(g2[1] ? 8 : 0), err: 1'b0});
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL tie_resp2_valid got=%b exp=%b", v, x.id); end
        n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL tie_resp2_rdata got=%h exp=%h", d, x.rdata); end
        ack();
    endtask

    task automatic test_range();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        int we0;
        logic [31:0] addrs [3];
        logic [2:0]  ports, wes, errs;
        bit same;
        addrs[0] = 32'd9; addrs[1] = 32'hFFFF_FFFE; addrs[2] = 32'd8;
        ports = 3'b010; wes = 3'b011; errs = 3'b011;
        we0 = we_count;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{id: ports[i] ? 2'b10 : 2'b01,
                           rdata: errs[i] ? 32'h0 : shadow_word(int'(addrs[i])),
                           err: errs[i]});
            accept_req(int'(ports[i]), addrs[i], wes[i], 32'h55AA_55AA);
            n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL range%0d_we got=%b exp=0", i, mem_write_en); end
            n_checks++; if (mem_address !== addrs[i]) begin n_fail++; $display("FAIL range%0d_addr got=%h exp=%h", i, mem_address, addrs[i]); end
            @(posedge clk); #1;
            wait_resp(v, d, e, cyc);
            x = sb.pop_front();
            n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL range%0d_valid got=%b exp=%b", i, v, x.id); end
            n_checks++; if (e !== x.err) begin n_fail++; $display("FAIL range%0d_err got=%b exp=%b", i, e, x.err); end
            n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL range%0d_rdata got=%h exp=%h", i, d, x.rdata); end
            ack();
        end
        n_checks++; if (we_count !== we0) begin n_fail++; $display("FAIL range_we_pulses got=%0d exp=%0d", we_count - we0, 0); end
        same = 1;
        for (int a = 0; a < MEM_BYTES; a++) if (mem[a] !== shadow[a]) same = 0;
        n_checks++; if (!same) begin n_fail++; $display("FAIL range_mem_unchanged got=%h_%h_%h exp=%h_%h_%h", mem_word(8), mem_word(4), mem_word(0), shadow_word(8), shadow_word(4), shadow_word(0)); end
    endtask

    task automatic test_backpressure();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        sb.push_back('{id: 2'b10, rdata: shadow_word(4), err: 1'b0});
        accept_req(1, 32'd4, 1'b0, 32'h0);
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL bp_valid0 got=%b exp=%b", v, x.id); end
        // a pending port-0 request and a stray ready on the non-granted bit
        bus.req_addr0 = 32'd0; bus.req_we0 = 1'b0;
        bus.req_valid = 2'b01;
        bus.resp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.resp_valid !== x.id) begin n_fail++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, bus.resp_valid, x.id); end
            n_checks++; if (bus.resp_rdata !== x.rdata) begin n_fail++; $display("FAIL bp_rdata c=%0d got=%h exp=%h", c, bus.resp_rdata, x.rdata); end
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready c=%0d got=%b exp=00", c, bus.req_ready); end
        end
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        ack();
        n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_released got=%b exp=00", bus.resp_valid); end
    endtask

    task automatic test_reset_access();
        logic [1:0] v; logic [31:0] d; logic e; int cyc; resp_t x;
        int we0;
        we0 = we_count;
        accept_req(0, 32'd0, 1'b1, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rsta_we got=%b exp=0", mem_write_en); end
        n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL rsta_addr got=%h exp=0", mem_address); end
        n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL rsta_wdata got=%h exp=0", mem_write_data); end
        n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rsta_resp_valid got=%b exp=00", bus.resp_valid); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rsta_req_ready got=%b exp=00", bus.req_ready); end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (we_count !== we0) begin n_fail++; $display("FAIL rsta_we_pulses got=%0d exp=0", we_count - we0); end
        n_checks++; if (mem_word(0) !== shadow_word(0)) begin n_fail++; $display("FAIL rsta_mem got=%h exp=%h", mem_word(0), shadow_word(0)); end
        n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rsta_no_resp got=%b exp=00", bus.resp_valid); end
        sb.push_back('{id: 2'b10, rdata: shadow_word(0), err: 1'b0});
        accept_req(1, 32'd0, 1'b0, 32'h0);
        @(posedge clk); #1;
        wait_resp(v, d, e, cyc);
        x = sb.pop_front();
        n_checks++; if (v !== x.id) begin n_fail++; $display("FAIL rsta_next_valid got=%b exp=%b", v, x.id); end
        n_checks++; if (d !== x.rdata) begin n_fail++; $display("FAIL rsta_next_rdata got=%h exp=%h", d, x.rdata); end
        ack();
    endtask

    initial begin
        bus.req_valid  = 2'b00;
        bus.req_addr0  = '0; bus.req_addr1  = '0;
        bus.req_we0    = 1'b0; bus.req_we1  = 1'b0;
        bus.req_wdata0 = '0; bus.req_wdata1 = '0;
        bus.resp_ready = 2'b00;
        test_reset();
        test_write();
        test_readback();
        test_tie();
        test_range();
        test_backpressure();
        test_reset_access();
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
